// File: rtl/passcode_checker.sv
// passcode_checker: checks a 4-digit one-hot keypad entry against a stored code and drives lock indicators
module passcode_checker #(
    parameter int          MAX_TRIES     = 3,
    parameter int          OPEN_TICKS    = 2000,
    parameter int          FAIL_TICKS    = 400,
    parameter int          LOCKOUT_TICKS = 12000,
    parameter logic [39:0] DEFAULT_CODE  = {10'h002, 10'h004, 10'h008, 10'h010}
) (
    input  logic       clk_400hz,
    input  logic       reset,
    input  logic [9:0] i_nums0,
    input  logic [9:0] i_nums1,
    input  logic [9:0] i_nums2,
    input  logic [9:0] i_nums3,
    input  logic       confirm,
    input  logic       set_mode,
    output logic       o_unlock,
    output logic       o_set_active,
    output logic       o_error,
    output logic       o_locked,
    output logic [1:0] o_tries_left,
    output logic       o_clear_entry,
    output logic [2:0] o_state
);
    localparam int MAX_TICKS = (OPEN_TICKS > FAIL_TICKS)
        ? ((OPEN_TICKS > LOCKOUT_TICKS) ? OPEN_TICKS : LOCKOUT_TICKS)
        : ((FAIL_TICKS > LOCKOUT_TICKS) ? FAIL_TICKS : LOCKOUT_TICKS);
    localparam int TW = ($clog2(MAX_TICKS) > 0) ? $clog2(MAX_TICKS) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        OPEN    = 3'd1,
        FAIL    = 3'd2,
        LOCKOUT = 3'd3,
        SET_NEW = 3'd4
    } state_t;

    state_t        state;
    logic [39:0]   code;
    logic [39:0]   entry;
    logic [TW-1:0] timer;
    logic [1:0]    tries;
    logic          prev_confirm;
    logic          prev_set;
    logic          confirm_edge;
    logic          set_edge;
    logic          complete;
    logic          match;

    assign entry        = {i_nums0, i_nums1, i_nums2, i_nums3};
    assign complete     = $onehot(i_nums0) && $onehot(i_nums1) && $onehot(i_nums2) && $onehot(i_nums3);
    assign match        = entry == code;
    assign confirm_edge = confirm & ~prev_confirm;
    assign set_edge     = set_mode & ~prev_set;
    assign o_state      = state;
    assign o_tries_left = tries;

    // Main FSM: timer is loaded with TICKS-1 on entry so each timed state lasts exactly TICKS cycles
    always_ff @(posedge clk_400hz) begin
        if (reset) begin
            state         <= IDLE;
            code          <= DEFAULT_CODE;
            tries         <= 2'(MAX_TRIES);
            timer         <= '0;
            prev_confirm  <= confirm;
            prev_set      <= set_mode;
            o_unlock      <= 1'b0;
            o_set_active  <= 1'b0;
            o_error       <= 1'b0;
            o_locked      <= 1'b0;
            o_clear_entry <= 1'b0;
        end else begin
            prev_confirm  <= confirm;
            prev_set      <= set_mode;
            o_clear_entry <= 1'b0;
            case (state)
                IDLE: begin
                    o_error <= 1'b0;
                    if (confirm_edge) begin
                        if (!complete) begin
                            o_error <= 1'b1;
                        end else if (match) begin
                            state         <= OPEN;
                            o_unlock      <= 1'b1;
                            tries         <= 2'(MAX_TRIES);
                            timer         <= TW'(OPEN_TICKS - 1);
                            o_clear_entry <= 1'b1;
                        end else if (tries <= 2'd1) begin
                            state         <= LOCKOUT;
                            o_locked      <= 1'b1;
                            tries         <= 2'd0;
                            timer         <= TW'(LOCKOUT_TICKS - 1);
                            o_clear_entry <= 1'b1;
                        end else begin
                            state         <= FAIL;
                            o_error       <= 1'b1;
                            tries         <= tries - 2'd1;
                            timer         <= TW'(FAIL_TICKS - 1);
                            o_clear_entry <= 1'b1;
                        end
                    end
                end
                OPEN: begin
                    if (confirm_edge || (!set_edge && timer == '0)) begin
                        state    <= IDLE;
                        o_unlock <= 1'b0;
                    end else if (set_edge) begin
                        state         <= SET_NEW;
                        o_unlock      <= 1'b0;
                        o_set_active  <= 1'b1;
                        timer         <= TW'(OPEN_TICKS - 1);
                        o_clear_entry <= 1'b1;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                FAIL: begin
                    if (timer == '0) begin
                        state   <= IDLE;
                        o_error <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                LOCKOUT: begin
                    if (timer == '0) begin
                        state    <= IDLE;
                        o_locked <= 1'b0;
                        tries    <= 2'(MAX_TRIES);
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                SET_NEW: begin
                    o_error <= 1'b0;
                    if (confirm_edge && complete) begin
                        state         <= IDLE;
                        code          <= entry;
                        o_set_active  <= 1'b0;
                        o_clear_entry <= 1'b1;
                    end else if ((set_edge && !confirm_edge) || timer == '0) begin
                        state        <= IDLE;
                        o_set_active <= 1'b0;
                    end else begin
                        timer   <= timer - 1'b1;
                        o_error <= confirm_edge;
                    end
                end
                default: begin
                    state        <= IDLE;
                    o_unlock     <= 1'b0;
                    o_set_active <= 1'b0;
                    o_error      <= 1'b0;
                    o_locked     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_passcode_checker.sv
// tb_passcode_checker: directed scoreboard bench for passcode_checker with shortened timeouts
module tb_passcode_checker;
    logic       clk_400hz = 1'b0;
    logic       reset     = 1'b1;
    logic       confirm   = 1'b0;
    logic       set_mode  = 1'b0;
    logic [9:0] i_nums0   = '0;
    logic [9:0] i_nums1   = '0;
    logic [9:0] i_nums2   = '0;
    logic [9:0] i_nums3   = '0;
    logic       o_unlock;
    logic       o_set_active;
    logic       o_error;
    logic       o_locked;
    logic [1:0] o_tries_left;
    logic       o_clear_entry;
    logic [2:0] o_state;

    localparam logic [2:0] S_IDLE = 3'd0, S_OPEN = 3'd1, S_FAIL = 3'd2, S_LOCK = 3'd3, S_SET = 3'd4;

    passcode_checker #(
        .MAX_TRIES(3), .OPEN_TICKS(8), .FAIL_TICKS(4), .LOCKOUT_TICKS(16)
    ) dut (
        .clk_400hz(clk_400hz), .reset(reset),
        .i_nums0(i_nums0), .i_nums1(i_nums1), .i_nums2(i_nums2), .i_nums3(i_nums3),
        .confirm(confirm), .set_mode(set_mode),
        .o_unlock(o_unlock), .o_set_active(o_set_active), .o_error(o_error), .o_locked(o_locked),
        .o_tries_left(o_tries_left), .o_clear_entry(o_clear_entry), .o_state(o_state)
    );

    // Free-running clock
    always #5 clk_400hz = ~clk_400hz;

    typedef struct {
        string      tag;
        logic [9:0] v;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Output vector layout: {state, unlock, set_active, error, locked, tries_left, clear_entry}
    function automatic logic [9:0] mk(input logic [2:0] st, input logic u, input logic s, input logic e,
                                      input logic l, input logic [1:0] t, input logic c);
        return {st, u, s, e, l, t, c};
    endfunction

    task automatic expect_out(input string tag, input logic [9:0] v);
        exp_t x;
        x.tag = tag;
        x.v   = v;
        sb.push_back(x);
    endtask

    task automatic tick();
        exp_t       x;
        logic [9:0] got;
        @(posedge clk_400hz);
        #1;
        if (sb.size() > 0) begin
            x   = sb.pop_front();
            got = {o_state, o_unlock, o_set_active, o_error, o_locked, o_tries_left, o_clear_entry};
            checks++;
            assert (got === x.v)
            else begin
                errors++;
                $error("FAIL %s: observed=%b required=%b", x.tag, got, x.v);
            end
        end
    endtask

    task automatic enter(input int a, input int b, input int c, input int d);
        i_nums0 = 10'd1 << a;
        i_nums1 = 10'd1 << b;
        i_nums2 = 10'd1 << c;
        i_nums3 = 10'd1 << d;
    endtask

    task automatic fail_attempt(input string tag, input logic [1:0] t);
        confirm = 1'b1;
        expect_out({tag, "_fail_enter"}, mk(S_FAIL, 0, 0, 1, 0, t, 1));
        tick();
        confirm = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_out({tag, "_fail_hold"}, mk(S_FAIL, 0, 0, 1, 0, t, 0));
            tick();
        end
        expect_out({tag, "_fail_exit"}, mk(S_IDLE, 0, 0, 0, 0, t, 0));
        tick();
    endtask

    initial begin
        tick();
        tick();
        expect_out("reset", mk(S_IDLE, 0, 0, 0, 0, 3, 0));
        tick();
        reset = 1'b0;

        enter(1, 2, 3, 4);
        confirm = 1'b1;
        expect_out("t1_open", mk(S_OPEN, 1, 0, 0, 0, 3, 1));
        tick();
        confirm = 1'b0;
        for (int i = 1; i < 8; i++) begin
            expect_out("t1_open_hold", mk(S_OPEN, 1, 0, 0, 0, 3, 0));
            tick();
        end
        expect_out("t1_timeout", mk(S_IDLE, 0, 0, 0, 0, 3, 0));
        tick();

        enter(5, 5, 5, 5);
        fail_attempt("t2a", 2);
        fail_attempt("t2b", 1);
        confirm = 1'b1;
        expect_out("t2_lock", mk(S_LOCK, 0, 0, 0, 1, 0, 1));
        tick();
        for (int i = 1; i < 16; i++) begin
            confirm  = (i == 4);
            set_mode = (i == 6);
            expect_out("t2_lock_hold", mk(S_LOCK, 0, 0, 0, 1, 0, 0));
            tick();
        end
        confirm  = 1'b0;
        set_mode = 1'b0;
        expect_out("t2_unlockout", mk(S_IDLE, 0, 0, 0, 0, 3, 0));
        tick();

        enter(1, 2, 3, 4);
        i_nums2 = '0;
        i_nums3 = '0;
        confirm = 1'b1;
        expect_out("t3_incomplete", mk(S_IDLE, 0, 0, 1, 0, 3, 0));
        tick();
        confirm = 1'b0;
        expect_out("t3_pulse_end", mk(S_IDLE, 0, 0, 0, 0, 3, 0));
        tick();
        enter(1, 2, 3, 4);
        i_nums2 = 10'h018;
        confirm = 1'b1;
        expect_out("t3_two_hot", mk(S_IDLE, 0, 0, 1, 0, 3, 0));
        tick();
        confirm = 1'b0;
        expect_out("t3_two_hot_end", mk(S_IDLE, 0, 0, 0, 0, 3, 0));
        tick();

        enter(1, 2, 3, 4);
        confirm = 1'b1;
        expect_out("t4_open", mk(S_OPEN, 1, 0, 0, 0, 3, 1));
        tick();
        confirm = 1'b0;
        expect_out("t4_open_hold", mk(S_OPEN, 1, 0, 0, 0, 3, 0));
        tick();
        set_mode = 1'b1;
        expect_out("t4_set_new", mk(S_SET, 0, 1, 0, 0, 3, 1));
        tick();
        set_mode = 1'b0;
        enter(9, 0, 7, 2);
        expect_out("t4_set_hold", mk(S_SET, 0, 1, 0, 0, 3, 0));
        tick();
        confirm = 1'b1;
        expect_out("t4_store", mk(S_IDLE, 0, 0, 0, 0, 3, 1));
        tick();
        confirm = 1'b0;
        expect_out("t4_idle", mk(S_IDLE, 0, 0, 0, 0, 3, 0));
        tick();
        enter(1, 2, 3, 4);
        fail_attempt("t4_old", 2);
        enter(9, 0, 7, 2);
        confirm = 1'b1;
        expect_out("t4_new_open", mk(S_OPEN, 1, 0, 0, 0, 3, 1));
        tick();
        confirm = 1'b0;
        expect_out("t4_new_hold", mk(S_OPEN, 1, 0, 0, 0, 3, 0));
        tick();

        confirm  = 1'b1;
        set_mode = 1'b1;
        expect_out("t5_relock", mk(S_IDLE, 0, 0, 0, 0, 3, 0));
        tick();
        confirm  = 1'b0;
        set_mode = 1'b0;
        expect_out("t5_no_set", mk(S_IDLE, 0, 0, 0, 0, 3, 0));
        tick();

        enter(5, 5, 5, 5);
        fail_attempt("t6a", 2);
        fail_attempt("t6b", 1);
        confirm = 1'b1;
        expect_out("t6_lock", mk(S_LOCK, 0, 0, 0, 1, 0, 1));
        tick();
        for (int i = 0; i < 3; i++) begin
            expect_out("t6_lock_hold", mk(S_LOCK, 0, 0, 0, 1, 0, 0));
            tick();
        end
        reset = 1'b1;
        expect_out("t6_reset", mk(S_IDLE, 0, 0, 0, 0, 3, 0));
        tick();
        reset = 1'b0;
        expect_out("t6_held_confirm", mk(S_IDLE, 0, 0, 0, 0, 3, 0));
        tick();
        expect_out("t6_held_confirm2", mk(S_IDLE, 0, 0, 0, 0, 3, 0));
        tick();
        confirm = 1'b0;
        enter(1, 2, 3, 4);
        expect_out("t6_release", mk(S_IDLE, 0, 0, 0, 0, 3, 0));
        tick();
        confirm = 1'b1;
        expect_out("t6_default_code", mk(S_OPEN, 1, 0, 0, 0, 3, 1));
        tick();
        confirm = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
